// File: rtl/sram_pkg.sv
// Shared types and constants for the two-phase 16-bit SRAM memory controller.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_e;

  localparam int DATA_BASE_DEF = 1024;
  localparam int HALF_BIT      = 0;

endpackage

// File: rtl/sram_mem_ctrl.sv
// Memory-stage controller: 32-bit load/store as two 16-bit SRAM phases.
// Optional one-entry last-read buffer when SRAM_READ_HIT_EN is defined.
module sram_mem_ctrl
  import sram_pkg::*;
#(
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_BASE   = DATA_BASE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic               wr_q;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [SRAM_AW-1:0] sa_q;
  logic [15:0]        dq_q;

  logic               req;
  logic               last;
  logic               hit;
  logic               start;
  logic [SRAM_AW-2:0] word;

  assign req   = mem_r_en | mem_w_en;
  assign last  = (cnt_q == LAST);
  assign start = (state_q == IDLE) & req & ~hit;
  assign word  = (SRAM_AW-1)'((address - 32'(DATA_BASE)) >> 2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req && !hit) begin
          state_d = LOW;
          cnt_d   = '0;
        end
      end
      LOW: begin
        if (last) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready      = (state_q == DONE)
               | ((state_q == IDLE) & (~req | hit));
    sram_dq_oe = wr_q & ((state_q == LOW) | (state_q == HIGH));
    sram_we_n  = ~sram_dq_oe;
  end

  // Request is latched on leaving IDLE; later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sa_q    <= '0;
      dq_q    <= '0;
    end else begin
      if (start) begin
        wr_q    <= mem_w_en;
        word_q  <= word;
        wdata_q <= write_data;
        sa_q    <= {word, 1'b0};
        dq_q    <= write_data[15:0];
      end
      if (state_q == LOW && last) begin
        sa_q <= {word_q, 1'b0} | (SRAM_AW'(1) << HALF_BIT);
        dq_q <= wdata_q[31:16];
        if (!wr_q) rdata_q[15:0] <= sram_dq_in;
      end
      if (state_q == HIGH && last && !wr_q) begin
        rdata_q[31:16] <= sram_dq_in;
      end
    end
  end

  assign sram_addr   = sa_q;
  assign sram_dq_out = dq_q;

`ifdef SRAM_READ_HIT_EN
  logic [SRAM_AW-2:0] tag_q;
  logic               hv_q;
  logic [31:0]        hdata_q;

  assign hit = (state_q == IDLE) & mem_r_en & ~mem_w_en
             & hv_q & (tag_q == word);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q   <= '0;
      hv_q    <= 1'b0;
      hdata_q <= '0;
    end else begin
      if (state_q == IDLE && mem_w_en) hv_q <= 1'b0;
      if (state_q == HIGH && last && !wr_q) begin
        hv_q    <= 1'b1;
        tag_q   <= word_q;
        hdata_q <= {sram_dq_in, rdata_q[15:0]};
      end
    end
  end

  assign read_data = hit ? hdata_q : rdata_q;
`else
  assign hit       = 1'b0;
  assign read_data = rdata_q;
`endif

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl: vector table, random ops vs a
// word-level reference model, and hand-written reset / wait-state sequences.
module tb_sram_mem_ctrl;

  localparam int AW = 18;
`ifdef SRAM_READ_HIT_EN
  localparam bit HIT = 1'b1;
`else
  localparam bit HIT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic r0, w0, rdy0, oe0, we0;
  logic [31:0] a0, wd0, rd0;
  logic [AW-1:0] sa0;
  logic [15:0] dqo0, dqi0;
  logic r1, w1, rdy1, oe1, we1;
  logic [31:0] a1, wd1, rd1;
  logic [AW-1:0] sa1;
  logic [15:0] dqo1, dqi1;

  sram_mem_ctrl #(.SRAM_AW(AW), .WAIT_CYCLES(2), .DATA_BASE(1024)) u_dut (
    .clk(clk), .rst(rst), .mem_r_en(r0), .mem_w_en(w0),
    .address(a0), .write_data(wd0), .read_data(rd0), .ready(rdy0),
    .sram_addr(sa0), .sram_dq_out(dqo0), .sram_dq_in(dqi0),
    .sram_dq_oe(oe0), .sram_we_n(we0));

  sram_mem_ctrl #(.SRAM_AW(AW), .WAIT_CYCLES(1), .DATA_BASE(1024)) u_dut1 (
    .clk(clk), .rst(rst), .mem_r_en(r1), .mem_w_en(w1),
    .address(a1), .write_data(wd1), .read_data(rd1), .ready(rdy1),
    .sram_addr(sa1), .sram_dq_out(dqo1), .sram_dq_in(dqi1),
    .sram_dq_oe(oe1), .sram_we_n(we1));

  // behavioural half-word SRAMs, default content 0
  logic [15:0] m0 [int];
  logic [15:0] m1 [int];
  always @(negedge clk) begin
    if (!we0) m0[int'(sa0)] = dqo0;
    dqi0 = m0.exists(int'(sa0)) ? m0[int'(sa0)] : 16'h0;
    if (!we1) m1[int'(sa1)] = dqo1;
    dqi1 = m1.exists(int'(sa1)) ? m1[int'(sa1)] : 16'h0;
  end

  bit sel;
  logic rdy, oe, we;
  logic [31:0] rdv_w;
  logic [AW-1:0] sa;
  logic [15:0] dqo;
  assign rdy   = sel ? rdy1 : rdy0;
  assign oe    = sel ? oe1 : oe0;
  assign we    = sel ? we1 : we0;
  assign rdv_w = sel ? rd1 : rd0;
  assign sa    = sel ? sa1 : sa0;
  assign dqo   = sel ? dqo1 : dqo0;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: 32-bit words indexed by SRAM word number
  logic [31:0] ref_mem [int];
  logic [31:0] ref_rd = 32'h0;
  bit hv = 1'b0;
  int htag = 0;

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] d;
    d = a - 32'd1024;
    return int'((d / 4) % 32'd131072);
  endfunction

  task automatic model_step(input bit rd, input bit wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] exp_rd, output int exp_stall,
                            output logic [17:0] exp_lo, output bit exp_hit);
    int w;
    w = word_of(addr);
    exp_lo = 18'(w * 2);
    exp_hit = 1'b0;
    exp_stall = 5;
    if (wr) begin
      ref_mem[w] = wdata;
      hv = 1'b0;
    end else if (rd) begin
      if (HIT && hv && htag == w) begin
        exp_hit = 1'b1;
        exp_stall = 0;
      end
      ref_rd = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
      hv = 1'b1;
      htag = w;
    end
    exp_rd = ref_rd;
  endtask

  task automatic do_op(input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int stall, output logic [17:0] alo,
                       output logic [17:0] ahi, output logic [15:0] dlo,
                       output logic [15:0] dhi, output logic oe_lo,
                       output logic we_lo, output logic [31:0] rdv,
                       output logic [17:0] a_bef, output logic [17:0] a_aft);
    int w;
    w = sel ? 1 : 2;
    alo = '0; ahi = '0; dlo = '0; dhi = '0; oe_lo = 1'b0; we_lo = 1'b1;
    a_bef = sa;
    if (sel) begin r1 = rd; w1 = wr; a1 = addr; wd1 = wdata; end
    else     begin r0 = rd; w0 = wr; a0 = addr; wd0 = wdata; end
    #1;
    stall = 0;
    while (!rdy && stall < 40) begin
      @(negedge clk); #1;
      stall++;
      if (stall == 1) begin
        alo = sa; dlo = dqo; oe_lo = oe; we_lo = we;
      end
      if (stall == w + 1) begin
        ahi = sa; dhi = dqo;
      end
    end
    rdv = rdv_w;
    a_aft = sa;
    r0 = 0; w0 = 0; r1 = 0; w1 = 0;
    @(negedge clk);
  endtask

  task automatic apply(input string nm, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input int exp_stall,
                       input logic [17:0] exp_lo);
    int st;
    logic [17:0] alo, ahi, ab, aa;
    logic [15:0] dlo, dhi;
    logic ol, wl;
    logic [31:0] rv;
    do_op(rd, wr, addr, wdata, st, alo, ahi, dlo, dhi, ol, wl, rv, ab, aa);
    check({nm, ".stall"}, st, exp_stall);
    check({nm, ".rdata"}, rv, exp_rd);
    if (exp_stall == 0) begin
      check({nm, ".addr_hold"}, aa, ab);
    end else begin
      check({nm, ".addr_lo"}, alo, exp_lo);
      check({nm, ".addr_hi"}, ahi, exp_lo + 18'd1);
      check({nm, ".oe"}, ol, wr);
      check({nm, ".we_n"}, wl, !wr);
      if (wr) begin
        check({nm, ".dq_lo"}, dlo, wdata[15:0]);
        check({nm, ".dq_hi"}, dhi, wdata[31:16]);
      end
    end
  endtask

  task automatic run(input string nm, input bit rd, input bit wr,
                     input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] er;
    int es;
    logic [17:0] el;
    bit eh;
    model_step(rd, wr, addr, wdata, er, es, el, eh);
    apply(nm, rd, wr, addr, wdata, er, es, el);
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_stall;
    logic [17:0] exp_lo;
  } vec_t;

  vec_t vt [7];

  initial begin
    logic [31:0] er;
    int es, st;
    logic [17:0] el, alo, ahi, ab, aa;
    logic [15:0] dlo, dhi;
    logic ol, wl;
    logic [31:0] rv;
    bit eh;

    vt[0] = '{1'b0, 1'b1, 32'd1024, 32'hFFFF_F9F6, 32'h0, 5, 18'd0};
    vt[1] = '{1'b1, 1'b0, 32'd1024, 32'h0, 32'hFFFF_F9F6, 5, 18'd0};
    vt[2] = '{1'b1, 1'b1, 32'd1032, 32'd2, 32'hFFFF_F9F6, 5, 18'd4};
    vt[3] = '{1'b1, 1'b0, 32'd1032, 32'h0, 32'd2, 5, 18'd4};
    vt[4] = '{1'b1, 1'b0, 32'd1020, 32'h0, 32'h0, 5, 18'd262142};
    vt[5] = '{1'b0, 1'b1, 32'd1044, 32'd1546, 32'h0, 5, 18'd10};
    vt[6] = '{1'b1, 1'b0, 32'd1044, 32'h0, 32'd1546, 5, 18'd10};

    sel = 0;
    r0 = 0; w0 = 0; a0 = 0; wd0 = 0;
    r1 = 0; w1 = 0; a1 = 0; wd1 = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #10;
    check("reset.ready", rdy0, 1'b1);
    check("reset.rdata", rd0, 32'h0);
    check("reset.we_n", we0, 1'b1);
    check("reset.oe", oe0, 1'b0);
    check("reset.addr", sa0, 32'h0);
    check("reset.dq_out", dqo0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      model_step(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, er, es, el, eh);
      apply($sformatf("vec%0d", i), vt[i].rd, vt[i].wr, vt[i].addr,
            vt[i].wdata, vt[i].exp_rd, vt[i].exp_stall, vt[i].exp_lo);
    end
    check("both.sram_lo", m0.exists(4) ? m0[4] : 16'hxxxx, 32'd2);
    check("both.sram_hi", m0.exists(5) ? m0[5] : 16'hxxxx, 32'd0);

    // no request: ready stays high and the SRAM port is untouched
    ab = sa0;
    repeat (3) begin
      @(negedge clk); #1;
      check("idle.ready", rdy0, 1'b1);
      check("idle.we_n", we0, 1'b1);
    end
    check("idle.addr", sa0, ab);

`ifdef SRAM_READ_HIT_EN
    model_step(1, 0, 32'd1028, 0, er, es, el, eh);
    apply("hit.first", 1, 0, 32'd1028, 0, 32'h0, 5, 18'd2);
    model_step(1, 0, 32'd1028, 0, er, es, el, eh);
    apply("hit.second", 1, 0, 32'd1028, 0, 32'h0, 0, 18'd2);
    model_step(0, 1, 32'd2000, 32'hA5A5_5A5A, er, es, el, eh);
    apply("hit.store", 0, 1, 32'd2000, 32'hA5A5_5A5A, 32'h0, 5, 18'd488);
    model_step(1, 0, 32'd1028, 0, er, es, el, eh);
    apply("hit.third", 1, 0, 32'd1028, 0, 32'h0, 5, 18'd2);
`endif

    for (int i = 0; i < 40; i++) begin
      int op;
      logic [31:0] ad, wd;
      op = $urandom_range(0, 9);
      ad = 32'd1024 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      wd = $urandom;
      if (op == 0) begin
        @(negedge clk); #1;
        check($sformatf("rnd%0d.idle_ready", i), rdy0, 1'b1);
      end else begin
        run($sformatf("rnd%0d", i), op >= 6 || op == 1, op <= 5, ad, wd);
      end
    end

    // reset in the middle of a load's high phase
    run("pre_rst.st", 0, 1, 32'd1024, 32'h1234_5678);
    run("pre_rst.ld", 1, 0, 32'd1024, 0);
    r0 = 1; a0 = 32'd1036;
    repeat (3) @(negedge clk);
    #1;
    check("midrst.in_high", sa0, 32'd7);
    rst = 1'b0;
    #1;
    r0 = 0;
    #1;
    check("midrst.rdata", rd0, 32'h0);
    check("midrst.we_n", we0, 1'b1);
    check("midrst.oe", oe0, 1'b0);
    check("midrst.addr", sa0, 32'h0);
    check("midrst.ready", rdy0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("postrst.ready", rdy0, 1'b1);
    check("postrst.rdata", rd0, 32'h0);
    ref_rd = 32'h0;
    hv = 1'b0;
    @(negedge clk);
    run("postrst.ld", 1, 0, 32'd1024, 0);

    // single wait-state instance
    sel = 1;
    @(negedge clk);
    do_op(0, 1, 32'd1044, 32'd1546, st, alo, ahi, dlo, dhi, ol, wl, rv, ab, aa);
    check("w1.st.stall", st, 3);
    check("w1.st.addr_lo", alo, 32'd10);
    check("w1.st.addr_hi", ahi, 32'd11);
    check("w1.st.dq_lo", dlo, 32'h060A);
    check("w1.st.dq_hi", dhi, 32'h0);
    check("w1.st.we_n", wl, 1'b0);
    do_op(1, 0, 32'd1044, 32'h0, st, alo, ahi, dlo, dhi, ol, wl, rv, ab, aa);
    check("w1.ld.stall", st, 3);
    check("w1.ld.rdata", rv, 32'd1546);
    check("w1.ld.oe", ol, 1'b0);
    check("w1.sram_lo", m1.exists(10) ? m1[10] : 16'hxxxx, 32'h060A);
    sel = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
